// File: rtl/fir_mac_sequencer.sv
// Tap scheduler for a shared pipelined complex multiplier and accumulator:
// pulls samples, issues one tap per cycle and tracks products in flight.
module fir_mac_sequencer #(
   parameter int NTAPS    = 4,
   parameter int MULT_LAT = 6,
   parameter int TAPW     = $clog2(NTAPS)
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            fifo_empty,
   input  logic            PushCoef,
   output logic            fifo_PullOut,
   output logic            mult_issue,
   output logic [TAPW-1:0] tap_idx,
   output logic            acc_load,
   output logic            acc_en,
   output logic            PushOut,
   output logic            busy,
   output logic            coef_err
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [TAPW-1:0]       cnt_r;
   logic [TAPW-1:0]       cnt_s;
   logic [MULT_LAT-1:0]   vld_r;
   logic [MULT_LAT-1:0]   first_r;
   logic [MULT_LAT-1:0]   last_r;
   logic                  push_r;
   logic                  coef_err_r;
   logic                  coef_hold_r;
   logic                  pull_s;
   logic                  issue_s;
   logic                  last_tap_s;
   logic                  busy_s;

   // Next-state, tap counter and pull decision
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      pull_s     = 1'b0;
      issue_s    = 1'b0;
      last_tap_s = (cnt_r == TAPW'(NTAPS - 1));
      case (state_r)
         IDLE: begin
            if (!fifo_empty && !PushCoef) begin
               pull_s  = 1'b1;
               state_s = ISSUE;
               cnt_s   = {TAPW{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            issue_s = 1'b1;
            if (last_tap_s) begin
               cnt_s = {TAPW{1'b0}};
               // a coefficient write seen during this sample also blocks the back-to-back pull
               if (!fifo_empty && !PushCoef && !coef_hold_r) begin
                  pull_s  = 1'b1;
                  state_s = ISSUE;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               cnt_s = cnt_r + TAPW'(1);
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {TAPW{1'b0}};
         end
      endcase
   end

   assign busy_s = (state_r == ISSUE) | (|vld_r) | push_r;

   // State, counter and coefficient-write bookkeeping
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r     <= IDLE;
         cnt_r       <= {TAPW{1'b0}};
         coef_err_r  <= 1'b0;
         coef_hold_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         coef_err_r <= coef_err_r | (PushCoef & busy_s);
         if (state_r == ISSUE) begin
            coef_hold_r <= coef_hold_r | PushCoef;
         end else begin
            coef_hold_r <= 1'b0;
         end
      end
   end

   // In-flight product tracking and completion pulse
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         vld_r   <= {MULT_LAT{1'b0}};
         first_r <= {MULT_LAT{1'b0}};
         last_r  <= {MULT_LAT{1'b0}};
         push_r  <= 1'b0;
      end else begin
         vld_r[0]   <= issue_s;
         first_r[0] <= issue_s & (cnt_r == {TAPW{1'b0}});
         last_r[0]  <= issue_s & last_tap_s;
         for (int i = 1; i < MULT_LAT; i++) begin
            vld_r[i]   <= vld_r[i-1];
            first_r[i] <= first_r[i-1];
            last_r[i]  <= last_r[i-1];
         end
         push_r <= vld_r[MULT_LAT-1] & last_r[MULT_LAT-1];
      end
   end

   // Pull is gated so that every output is low while reset is held
   assign fifo_PullOut = pull_s & ~Reset;
   assign mult_issue   = issue_s;
   assign tap_idx      = issue_s ? cnt_r : {TAPW{1'b0}};
   assign acc_en       = vld_r[MULT_LAT-1];
   assign acc_load     = vld_r[MULT_LAT-1] & first_r[MULT_LAT-1];
   assign PushOut      = push_r;
   assign busy         = busy_s;
   assign coef_err     = coef_err_r;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: expected event cycles are queued
// per test and a negedge monitor pops and compares them as the DUT emits.
module tb_fir_mac_sequencer;

   logic       Clk;
   logic       Reset;
   logic       fifo_empty;
   logic       PushCoef;
   logic       fifo_PullOut;
   logic       mult_issue;
   logic [1:0] tap_idx;
   logic       acc_load;
   logic       acc_en;
   logic       PushOut;
   logic       busy;
   logic       coef_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int base   = 0;
   int rel;
   int exp_v;

   int q_pull[$];
   int q_iss[$];
   int q_acc[$];
   int q_push[$];

   fir_mac_sequencer #(.NTAPS(4), .MULT_LAT(6)) dut (
      .Clk(Clk), .Reset(Reset), .fifo_empty(fifo_empty), .PushCoef(PushCoef),
      .fifo_PullOut(fifo_PullOut), .mult_issue(mult_issue), .tap_idx(tap_idx),
      .acc_load(acc_load), .acc_en(acc_en), .PushOut(PushOut),
      .busy(busy), .coef_err(coef_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: encodings are cycle*16+tap for issues, cycle*2+load for accumulates
   always @(negedge Clk) begin
      rel = cyc - base;
      if (fifo_PullOut) begin
         exp_v = (q_pull.size() > 0) ? q_pull.pop_front() : -1;
         chk("pull_cycle", rel, exp_v);
      end
      if (mult_issue) begin
         exp_v = (q_iss.size() > 0) ? q_iss.pop_front() : -1;
         chk("issue_cycle_tap", rel * 16 + int'(tap_idx), exp_v);
      end
      if (acc_en) begin
         exp_v = (q_acc.size() > 0) ? q_acc.pop_front() : -1;
         chk("acc_cycle_load", rel * 2 + int'(acc_load), exp_v);
      end
      if (acc_load) chk("load_needs_en", int'(acc_en), 1);
      if (PushOut) begin
         exp_v = (q_push.size() > 0) ? q_push.pop_front() : -1;
         chk("push_cycle", rel, exp_v);
      end
   end

   task automatic start_test();
      @(posedge Clk);
      #1;
      base = cyc;
   endtask

   task automatic drive(input logic fe, input logic pc, input logic rst);
      fifo_empty = fe;
      PushCoef   = pc;
      Reset      = rst;
      @(negedge Clk);
   endtask

   task automatic adv();
      @(posedge Clk);
      #1;
   endtask

   task automatic end_test(input string name);
      chk({name, "_pull_left"}, q_pull.size(), 0);
      chk({name, "_iss_left"},  q_iss.size(),  0);
      chk({name, "_acc_left"},  q_acc.size(),  0);
      chk({name, "_push_left"}, q_push.size(), 0);
   endtask

   initial begin
      Reset      = 1'b1;
      fifo_empty = 1'b1;
      PushCoef   = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_coef_err", int'(coef_err), 0);
      chk("rst_issue", int'(mult_issue), 0);
      chk("rst_tap", int'(tap_idx), 0);
      chk("rst_acc", int'(acc_en), 0);
      chk("rst_push", int'(PushOut), 0);
      Reset = 1'b0;

      // Single sample
      q_pull.push_back(0);
      for (int k = 1; k <= 4; k++) q_iss.push_back(k * 16 + (k - 1));
      for (int k = 7; k <= 10; k++) q_acc.push_back(k * 2 + ((k == 7) ? 1 : 0));
      q_push.push_back(11);
      start_test();
      for (int k = 0; k < 30; k++) begin
         drive(k != 0, 1'b0, 1'b0);
         if (k == 11) chk("t1_busy_11", int'(busy), 1);
         if (k == 12) chk("t1_busy_12", int'(busy), 0);
         adv();
      end
      end_test("t1");

      // Three samples back to back
      q_pull.push_back(0); q_pull.push_back(4); q_pull.push_back(8);
      for (int k = 1; k <= 12; k++) q_iss.push_back(k * 16 + ((k - 1) % 4));
      for (int k = 7; k <= 18; k++) q_acc.push_back(k * 2 + (((k - 7) % 4 == 0) ? 1 : 0));
      q_push.push_back(11); q_push.push_back(15); q_push.push_back(19);
      start_test();
      for (int k = 0; k < 30; k++) begin
         drive(k > 8, 1'b0, 1'b0);
         adv();
      end
      end_test("t2");

      // PushCoef held in IDLE blocks the pull without flagging an error
      q_pull.push_back(5);
      for (int k = 6; k <= 9; k++) q_iss.push_back(k * 16 + (k - 6));
      for (int k = 12; k <= 15; k++) q_acc.push_back(k * 2 + ((k == 12) ? 1 : 0));
      q_push.push_back(16);
      start_test();
      for (int k = 0; k < 30; k++) begin
         drive(k > 5, k < 5, 1'b0);
         if (k == 3) chk("t3_busy_idle", int'(busy), 0);
         if (k == 4) chk("t3_coef_err_4", int'(coef_err), 0);
         if (k == 20) chk("t3_coef_err_20", int'(coef_err), 0);
         adv();
      end
      end_test("t3");

      // PushCoef pulse mid-sample
      q_pull.push_back(0);
      for (int k = 1; k <= 4; k++) q_iss.push_back(k * 16 + (k - 1));
      for (int k = 7; k <= 10; k++) q_acc.push_back(k * 2 + ((k == 7) ? 1 : 0));
      q_push.push_back(11);
      start_test();
      for (int k = 0; k < 30; k++) begin
         drive(!(k == 0 || k == 4), k == 3, 1'b0);
         if (k == 3) chk("t4_coef_err_3", int'(coef_err), 0);
         if (k == 4) chk("t4_coef_err_4", int'(coef_err), 1);
         if (k == 11) chk("t4_busy_11", int'(busy), 1);
         if (k == 25) chk("t4_coef_err_25", int'(coef_err), 1);
         adv();
      end
      end_test("t4");

      // Reset in the middle of a back-to-back stream
      q_pull.push_back(0); q_pull.push_back(4);
      for (int k = 1; k <= 4; k++) q_iss.push_back(k * 16 + (k - 1));
      start_test();
      for (int k = 0; k < 30; k++) begin
         drive(k >= 5, 1'b0, (k == 5 || k == 6));
         if (k == 4) chk("t5_coef_err_sticky", int'(coef_err), 1);
         if (k == 5) begin
            chk("t5_busy_rst", int'(busy), 0);
            chk("t5_issue_rst", int'(mult_issue), 0);
            chk("t5_tap_rst", int'(tap_idx), 0);
            chk("t5_coef_err_rst", int'(coef_err), 0);
         end
         if (k == 20) chk("t5_busy_20", int'(busy), 0);
         adv();
      end
      end_test("t5");

      // FIFO drains at cycle 2 and refills at cycle 9
      q_pull.push_back(0); q_pull.push_back(9);
      for (int k = 1; k <= 4; k++) q_iss.push_back(k * 16 + (k - 1));
      for (int k = 10; k <= 13; k++) q_iss.push_back(k * 16 + (k - 10));
      for (int k = 7; k <= 10; k++) q_acc.push_back(k * 2 + ((k == 7) ? 1 : 0));
      for (int k = 16; k <= 19; k++) q_acc.push_back(k * 2 + ((k == 16) ? 1 : 0));
      q_push.push_back(11); q_push.push_back(20);
      start_test();
      for (int k = 0; k < 30; k++) begin
         drive(!(k < 2 || k == 9), 1'b0, 1'b0);
         adv();
      end
      end_test("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Scheduler that time-shares one pipelined complex multiplier and one accumulator across the NTAPS coefficient taps of each input sample. It pulls samples from the input FIFO and issues one tap per cycle to the multiplier. It tracks the products in flight and drives accumulator load/enable and the output push. It sits between the sample FIFO, the coefficient bank/operand mux and the complex multiply–accumulate datapath.

## Interface
- NTAPS, 4: taps per sample; must be ≥2.
- MULT_LAT, 6: multiplier latency in cycles from issue to product valid; must be ≥1.
- TAPW, $clog2(NTAPS): tap index width.

- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  input sample FIFO empty.
- PushCoef  in  1  coefficient bank write in progress; blocks new sample pulls.
- fifo_PullOut  out  1  FIFO pop; read data is valid the following cycle.
- mult_issue  out  1  operand pair valid at multiplier input this cycle.
- tap_idx  out  TAPW  coefficient bank address / operand mux select for the issued tap.
- acc_load  out  1  accumulator := product (first tap of a sample).
- acc_en  out  1  accumulator := accumulator + product (also high when acc_load is high).
- PushOut  out  1  accumulator holds a completed sample result; 1-cycle pulse.
- busy  out  1  a sample is being issued or products are in flight.
- coef_err  out  1  sticky flag: PushCoef was seen while busy.

## Operation
- FSM states:
  - IDLE: if !fifo_empty && !PushCoef, assert fifo_PullOut (combinational) and go to ISSUE; otherwise stay.
  - ISSUE: tap counter runs 0..NTAPS-1, one tap per cycle, with mult_issue=1 and tap_idx=counter.
  - On the last tap: if !fifo_empty && !PushCoef, assert fifo_PullOut, reset the counter to 0 and stay in ISSUE (back-to-back). Otherwise go to IDLE.
- In-flight tracking: a MULT_LAT-deep shift register carries {valid, first, last} per issued tap.
  - first = tap 0; last = tap NTAPS-1.
  - Shift-register output drives acc_en=valid and acc_load=valid&first.
  - Registered valid&last drives PushOut one cycle later.
- busy = (state==ISSUE) | any valid bit in the shift register | pending PushOut.
- PushCoef while busy: pulls stay blocked and coef_err is set. The in-progress sample completes with whatever coefficients the bank presents; no abort.
- coef_err clears only on Reset.
- fifo_empty asserted mid-sample has no effect until the last-tap decision.
- tap_idx holds 0 when not issuing.

## Timing
- Reset values: state=IDLE, counter=0, shift register all 0, and all outputs 0.
- Reset mid-operation flushes all in-flight products. No PushOut, acc_en or acc_load is produced for them.
- Pull at cycle c → taps issued at cycles c+1..c+NTAPS.
- First product: acc_load and acc_en at c+1+MULT_LAT.
- acc_en stays high for NTAPS consecutive cycles.
- PushOut at c+NTAPS+MULT_LAT+1.
- Back-to-back throughput is one sample per NTAPS cycles. mult_issue stays continuously high with no bubble between samples.
- Simultaneous last tap and PushCoef=1: no pull, go to IDLE, coef_err set (busy still high).

## Test plan
- Single sample (NTAPS=4, MULT_LAT=6) with fifo_empty=0 for one cycle at c=0:
  - fifo_PullOut at 0 only.
  - mult_issue at 1–4 with tap_idx 0,1,2,3.
  - acc_load at 7; acc_en at 7–10.
  - PushOut at 11; busy falls at 12.
- Three samples available, FIFO non-empty throughout:
  - Pulls at 0, 4, 8; mult_issue continuous 1–12.
  - acc_load at 7, 11, 15.
  - PushOut at 11, 15, 19.
- PushCoef=1 in IDLE with FIFO non-empty for 5 cycles: no pull and coef_err stays 0. The first pull occurs in the cycle PushCoef drops.
- PushCoef pulsed at cycle 3 of a sample:
  - Issue completes through 4 and no pull occurs at 4.
  - coef_err=1 from cycle 4 onward.
  - PushOut still at 11.
- Reset asserted at cycle 5 of a back-to-back stream: all outputs 0 immediately. No acc_en or PushOut afterward until a new pull.
- FIFO goes empty at cycle 2 then refills at cycle 9: second pull at 9; no spurious issue in cycles 5–9.
